// File: rtl/tl_ram_responder_if.sv
// ============================================================================
// Module      : tl_ram_responder_if
// Description : TileLink-UH A/D channel bundle between an initiator and the
//               SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl_ram_responder_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     a_valid;
    logic                     a_ready;
    logic [2:0]               a_payload_opcode;
    logic [2:0]               a_payload_param;
    logic [1:0]               a_payload_source;
    logic [ADDRESS_WIDTH-1:0] a_payload_address;
    logic [2:0]               a_payload_size;
    logic [7:0]               a_payload_mask;
    logic [63:0]              a_payload_data;

    logic                     d_valid;
    logic                     d_ready;
    logic [2:0]               d_payload_opcode;
    logic [2:0]               d_payload_param;
    logic [1:0]               d_payload_source;
    logic [2:0]               d_payload_size;
    logic                     d_payload_denied;
    logic [63:0]              d_payload_data;
    logic                     d_payload_corrupt;

    modport master (
        output a_valid, a_payload_opcode, a_payload_param, a_payload_source,
               a_payload_address, a_payload_size, a_payload_mask, a_payload_data,
               d_ready,
        input  a_ready, d_valid, d_payload_opcode, d_payload_param,
               d_payload_source, d_payload_size, d_payload_denied,
               d_payload_data, d_payload_corrupt
    );

    modport slave (
        input  a_valid, a_payload_opcode, a_payload_param, a_payload_source,
               a_payload_address, a_payload_size, a_payload_mask, a_payload_data,
               d_ready,
        output a_ready, d_valid, d_payload_opcode, d_payload_param,
               d_payload_source, d_payload_size, d_payload_denied,
               d_payload_data, d_payload_corrupt
    );
endinterface

`default_nettype wire

// File: rtl/tl_ram_responder.sv
// ============================================================================
// Module      : tl_ram_responder
// Description : TileLink-UH Get/PutFullData responder over a single-ported
//               64-bit SRAM. Optional macro TL_RESP_JITTER_EN adds LFSR-driven
//               backpressure on a_ready and d_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_ram_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DEPTH_WORDS   = 4096,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    tl_ram_responder_if.slave tl_bus
);

    localparam int                     c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDRESS_WIDTH:0] c_WINDOW    = (ADDRESS_WIDTH+1)'(DEPTH_WORDS) << 3;
    localparam logic [2:0]             c_OP_GET    = 3'd4;
    localparam logic [2:0]             c_OP_PUT    = 3'd0;
    localparam logic [2:0]             c_D_ACK     = 3'd0;
    localparam logic [2:0]             c_D_ACKDATA = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    logic [63:0]            r_mem [DEPTH_WORDS];
    logic [63:0]            r_rd_data;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [3:0]             r_left;
    logic                   r_denied;
    logic [1:0]             r_source;
    logic [2:0]             r_size;
    logic                   r_d_valid;
    logic [2:0]             r_d_opcode;
    logic [ADDRESS_WIDTH:0] w_off;
    logic                   w_denied;
    logic [3:0]             w_beats;
    logic [c_IDX_W-1:0]     w_idx_al;
    logic                   w_a_rdy;
    logic                   w_a_fire;
    logic                   w_d_fire;
    logic                   w_load;
    logic                   w_wr_en;
    logic [c_IDX_W-1:0]     w_wr_idx;
    logic                   w_jit;
    logic                   w_a_gate;
    wire logic              w_unused = ^tl_bus.a_payload_param;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef TL_RESP_JITTER_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_jit    = r_lfsr[0];
    assign w_a_gate = ~r_lfsr[1];
`else
    assign w_jit    = 1'b0;
    assign w_a_gate = 1'b1;
`endif

    // Request decode; the window is aligned, so the offset drives both the
    // range check and the word index.
    assign w_off    = {1'b0, tl_bus.a_payload_address} - {1'b0, BASE_ADDRESS};
    assign w_denied = (w_off >= c_WINDOW);
    assign w_beats  = (tl_bus.a_payload_size <= 3'd3) ? 4'd1
                    : (4'd1 << (tl_bus.a_payload_size - 3'd3));
    assign w_idx_al = w_off[c_IDX_W+2:3] & ~c_IDX_W'(w_beats - 4'd1);

    assign w_a_rdy  = w_rst_n & (((r_state == S_IDLE) & w_a_gate) | (r_state == S_WRITE));
    assign w_a_fire = tl_bus.a_valid & w_a_rdy;
    assign w_d_fire = r_d_valid & tl_bus.d_ready;
    assign w_load   = (r_state == S_READ) & (r_left != 4'd0)
                    & (~r_d_valid | tl_bus.d_ready) & ~w_jit;

    assign w_wr_en  = w_a_fire & (((r_state == S_IDLE) & (tl_bus.a_payload_opcode == c_OP_PUT) & ~w_denied)
                                | ((r_state == S_WRITE) & ~r_denied));
    assign w_wr_idx = (r_state == S_IDLE) ? w_idx_al : r_ptr;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_a_fire) begin
                    if (tl_bus.a_payload_opcode == c_OP_GET) w_next = S_READ;
                    else if (w_beats == 4'd1)                w_next = S_ACK;
                    else                                     w_next = S_WRITE;
                end
            end
            S_READ:  if (w_d_fire && r_left == 4'd0)  w_next = S_IDLE;
            S_WRITE: if (w_a_fire && r_left == 4'd1)  w_next = S_ACK;
            S_ACK:   if (w_d_fire)                    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ptr      <= '0;
            r_left     <= 4'd0;
            r_denied   <= 1'b0;
            r_source   <= 2'd0;
            r_size     <= 3'd0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= c_D_ACK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_a_fire) begin
                        r_source <= tl_bus.a_payload_source;
                        r_size   <= tl_bus.a_payload_size;
                        r_denied <= w_denied;
                        if (tl_bus.a_payload_opcode == c_OP_GET) begin
                            r_ptr  <= w_idx_al;
                            r_left <= w_beats;
                        end else begin
                            r_ptr  <= w_idx_al + 1'b1;
                            r_left <= w_beats - 4'd1;
                        end
                    end
                end
                S_READ: begin
                    if (w_load) begin
                        r_d_valid  <= 1'b1;
                        r_d_opcode <= c_D_ACKDATA;
                        r_ptr      <= r_ptr + 1'b1;
                        r_left     <= r_left - 4'd1;
                    end else if (w_d_fire) begin
                        r_d_valid  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_a_fire) begin
                        r_ptr  <= r_ptr + 1'b1;
                        r_left <= r_left - 4'd1;
                    end
                end
                S_ACK: begin
                    if (r_d_valid) begin
                        if (tl_bus.d_ready) r_d_valid <= 1'b0;
                    end else if (!w_jit) begin
                        r_d_valid  <= 1'b1;
                        r_d_opcode <= c_D_ACK;
                    end
                end
                default: r_d_valid <= 1'b0;
            endcase
        end
    end

    // SRAM array and its registered read port; never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (tl_bus.a_payload_mask[b]) r_mem[w_wr_idx][8*b +: 8] <= tl_bus.a_payload_data[8*b +: 8];
            end
        end
        if (w_load) r_rd_data <= r_mem[r_ptr];
    end

    assign tl_bus.a_ready           = w_a_rdy;
    assign tl_bus.d_valid           = r_d_valid;
    assign tl_bus.d_payload_opcode  = r_d_opcode;
    assign tl_bus.d_payload_param   = 3'd0;
    assign tl_bus.d_payload_source  = r_source;
    assign tl_bus.d_payload_size    = r_size;
    assign tl_bus.d_payload_denied  = r_denied;
    assign tl_bus.d_payload_corrupt = 1'b0;
    // Denied reads and AccessAck carry zero data.
    assign tl_bus.d_payload_data    = ((r_d_opcode == c_D_ACKDATA) && !r_denied) ? r_rd_data : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_tl_ram_responder.sv
// ============================================================================
// Module      : tb_tl_ram_responder
// Description : Vector table, hand sequences and random traffic against a
//               word-array model of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tl_ram_responder;
    localparam int          AW     = 32;
    localparam int          DEPTH  = 256;
    localparam int          WIN    = DEPTH * 8;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [2:0]  OP_GET = 3'd4;
    localparam logic [2:0]  OP_PUT = 3'd0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_ram_responder_if #(.ADDRESS_WIDTH(AW)) tl_bus ();

    tl_ram_responder #(
        .ADDRESS_WIDTH(AW),
        .DEPTH_WORDS  (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tl_bus(tl_bus)
    );

    logic [63:0] model [DEPTH];
    logic [63:0] put_data [8];
    logic [7:0]  put_mask [8];
    logic [63:0] rx_data [8];
    logic [2:0]  rx_op   [8];
    logic        rx_den  [8];
    logic [1:0]  rx_src  [8];
    logic [2:0]  rx_size [8];
    int          rx_seen [8];
    int          first_seen;

    typedef struct {
        logic        is_put;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        exp_den;
        logic [63:0] exp_data;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int beats_of(input logic [2:0] s);
        return (s <= 3'd3) ? 1 : (1 << (s - 3'd3));
    endfunction

    function automatic logic is_denied(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (off < 0) || (off >= WIN);
    endfunction

    // Byte offset rounded down to the request's natural alignment, in words.
    function automatic int first_word(input logic [31:0] a, input logic [2:0] s);
        longint off, gran;
        off  = longint'({32'h0, a}) - longint'({32'h0, BASE});
        gran = (s <= 3'd3) ? 64'sd8 : (64'sd1 << s);
        return int'(((off / gran) * gran) / 8);
    endfunction

    task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [7:0] mask, input logic [63:0] data, input logic [1:0] src,
                          output int hs);
        int   t = 0;
        logic fired = 1'b0;
        hs = -100;
        tl_bus.a_valid = 1'b1;
        tl_bus.a_payload_opcode = op;
        tl_bus.a_payload_size = sz;
        tl_bus.a_payload_address = addr;
        tl_bus.a_payload_mask = mask;
        tl_bus.a_payload_data = data;
        tl_bus.a_payload_source = src;
        while (!fired && t < 50) begin
            @(negedge clk);
            fired = tl_bus.a_ready;
            hs = cyc;
            @(posedge clk); #1;
            t++;
        end
        tl_bus.a_valid = 1'b0;
        if (!fired) check("a_handshake_timeout", {63'd0, fired}, 64'd1);
    endtask

    // mode 0: d_ready held high; mode 1: d_ready pattern 1,0,0 repeating.
    task automatic collect(input int nbeats, input int mode, input bit chk_ar);
        int          got = 0;
        int          t = 0;
        bit          held = 1'b0;
        logic [63:0] hd = '0;
        first_seen = -1;
        while (got < nbeats && t < 300) begin
            tl_bus.d_ready = (mode == 0) ? 1'b1 : (t % 3 == 0);
            @(negedge clk);
            if (chk_ar) check("a_ready_during_burst", {63'd0, tl_bus.a_ready}, 64'd0);
            if (tl_bus.d_valid) begin
                if (first_seen < 0) first_seen = cyc;
                if (held) check("stall_hold", tl_bus.d_payload_data, hd);
                if (tl_bus.d_ready) begin
                    rx_data[got] = tl_bus.d_payload_data;
                    rx_op[got]   = tl_bus.d_payload_opcode;
                    rx_den[got]  = tl_bus.d_payload_denied;
                    rx_src[got]  = tl_bus.d_payload_source;
                    rx_size[got] = tl_bus.d_payload_size;
                    rx_seen[got] = cyc;
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = tl_bus.d_payload_data;
                end
            end else if (held) begin
                check("valid_withdrawn", {63'd0, tl_bus.d_valid}, 64'd1);
                held = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        tl_bus.d_ready = 1'b0;
        check("d_beats_received", 64'(got), 64'(nbeats));
    endtask

    task automatic do_put(input logic [31:0] addr, input logic [2:0] sz, input logic [1:0] src);
        int   nb, w, hs;
        logic den;
        nb  = beats_of(sz);
        den = is_denied(addr);
        w   = den ? 0 : first_word(addr, sz);
        for (int k = 0; k < nb; k++) a_send(OP_PUT, sz, addr, put_mask[k], put_data[k], src, hs);
        collect(1, 0, 1'b0);
        check("ack_opcode", 64'(rx_op[0]), 64'd0);
        check("ack_denied", 64'(rx_den[0]), 64'(den));
        check("ack_data",   rx_data[0], 64'd0);
        check("ack_source", 64'(rx_src[0]), 64'(src));
        check("ack_size",   64'(rx_size[0]), 64'(sz));
        if (!den) begin
            for (int k = 0; k < nb; k++)
                for (int b = 0; b < 8; b++)
                    if (put_mask[k][b]) model[w+k][8*b +: 8] = put_data[k][8*b +: 8];
        end
    endtask

    task automatic do_get(input logic [31:0] addr, input logic [2:0] sz, input logic [1:0] src,
                          input int mode, input bit chk_ar);
        int          nb, w, hs;
        logic        den;
        logic [63:0] exp;
        nb  = beats_of(sz);
        den = is_denied(addr);
        w   = den ? 0 : first_word(addr, sz);
        a_send(OP_GET, sz, addr, 8'h00, 64'h0, src, hs);
        collect(nb, mode, chk_ar);
        if (mode == 0) check("first_dvalid_latency", 64'(first_seen - hs), 64'd2);
        for (int k = 0; k < nb; k++) begin
            exp = den ? 64'd0 : model[w+k];
            check("get_data",   rx_data[k], exp);
            check("get_opcode", 64'(rx_op[k]), 64'd1);
            check("get_denied", 64'(rx_den[k]), 64'(den));
            check("get_source", 64'(rx_src[k]), 64'(src));
            check("get_size",   64'(rx_size[k]), 64'(sz));
            if (mode == 0 && k > 0) check("burst_gap", 64'(rx_seen[k] - rx_seen[k-1]), 64'd1);
        end
    endtask

    task automatic wait_a_ready(input string name);
        int   t = 0;
        logic seen = 1'b0;
        while (!seen && t < 10) begin
            @(negedge clk);
            seen = tl_bus.a_ready;
            if (tl_bus.d_valid) check("stale_beat_after_reset", 64'd1, 64'd0);
            @(posedge clk); #1;
            t++;
        end
        check(name, {63'd0, seen}, 64'd1);
    endtask

    initial begin : main
        int          got, t, hs, kind, mode;
        logic [2:0]  sz;
        logic [31:0] a;
        logic        put;

        tl_bus.a_valid = 1'b0;
        tl_bus.a_payload_opcode = 3'd0;
        tl_bus.a_payload_param = 3'd0;
        tl_bus.a_payload_source = 2'd0;
        tl_bus.a_payload_address = '0;
        tl_bus.a_payload_size = 3'd0;
        tl_bus.a_payload_mask = 8'h00;
        tl_bus.a_payload_data = 64'd0;
        tl_bus.d_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;

        vecs[0]  = '{1'b1, 3'd3, BASE + 32'h40,  8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 3'd3, BASE + 32'h40,  8'h00, 64'h0, 1'b0, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 3'd3, BASE + 32'h48,  8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 3'd3, BASE + 32'h48,  8'h00, 64'h0, 1'b0, 64'h00000000FFFFFFFF};
        vecs[4]  = '{1'b1, 3'd3, BASE + 32'h40,  8'hF0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 3'd3, BASE + 32'h47,  8'h00, 64'h0, 1'b0, 64'hAAAAAAAA55667788};
        vecs[6]  = '{1'b0, 3'd2, BASE + 32'h4C,  8'h00, 64'h0, 1'b0, 64'h00000000FFFFFFFF};
        vecs[7]  = '{1'b1, 3'd3, BASE + 32'h800, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'h0};
        vecs[8]  = '{1'b1, 3'd3, BASE - 32'h8,   8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'h0};
        vecs[9]  = '{1'b0, 3'd3, BASE + 32'h0,   8'h00, 64'h0, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 3'd3, BASE + 32'h7F8, 8'h00, 64'h0, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 3'd3, BASE + 32'h800, 8'h00, 64'h0, 1'b1, 64'h0};
        vecs[12] = '{1'b1, 3'd3, BASE + 32'h7F8, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
        vecs[13] = '{1'b0, 3'd3, BASE + 32'h7F8, 8'h00, 64'h0, 1'b0, 64'hDEADBEEFCAFEF00D};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_valid",  {63'd0, tl_bus.d_valid}, 64'd0);
        check("rst_a_ready",  {63'd0, tl_bus.a_ready}, 64'd0);
        check("rst_d_opcode", 64'(tl_bus.d_payload_opcode), 64'd0);
        check("rst_d_source", 64'(tl_bus.d_payload_source), 64'd0);
        check("rst_d_size",   64'(tl_bus.d_payload_size), 64'd0);
        check("rst_d_denied", {63'd0, tl_bus.d_payload_denied}, 64'd0);
        check("rst_d_data",   tl_bus.d_payload_data, 64'd0);
        reset = 1'b1;
        wait_a_ready("a_ready_after_release");

        // Zero the whole array so later partial writes start from a known word.
        for (int w = 0; w < DEPTH; w += 8) begin
            for (int k = 0; k < 8; k++) begin put_data[k] = 64'd0; put_mask[k] = 8'hFF; end
            do_put(BASE + 32'(w * 8), 3'd6, 2'd0);
        end

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_put) begin
                put_data[0] = vecs[i].data;
                put_mask[0] = vecs[i].mask;
                do_put(vecs[i].addr, vecs[i].size, 2'(i));
            end else begin
                do_get(vecs[i].addr, vecs[i].size, 2'(i), 0, 1'b0);
                check("vec_data", rx_data[0], vecs[i].exp_data);
            end
            check("vec_denied", 64'(rx_den[0]), 64'(vecs[i].exp_den));
        end

        // Eight-beat write then back-to-back and stalled reads.
        for (int k = 0; k < 8; k++) begin put_data[k] = 64'(k); put_mask[k] = 8'hFF; end
        do_put(BASE + 32'h80, 3'd6, 2'd2);
        do_get(BASE + 32'h80, 3'd6, 2'd2, 0, 1'b0);
        for (int k = 0; k < 8; k++) check("burst_beat", rx_data[k], 64'(k));
        do_get(BASE + 32'h80, 3'd6, 2'd1, 1, 1'b1);
        for (int k = 0; k < 8; k++) check("stall_beat", rx_data[k], 64'(k));
        @(negedge clk);
        check("a_ready_after_burst", {63'd0, tl_bus.a_ready}, 64'd1);
        @(posedge clk); #1;

        do_get(BASE + 32'h800, 3'd6, 2'd3, 0, 1'b0);

        // Reset in the middle of an eight-beat read.
        a_send(OP_GET, 3'd6, BASE + 32'h80, 8'h00, 64'h0, 2'd1, hs);
        tl_bus.d_ready = 1'b1;
        got = 0;
        t = 0;
        while (got < 4 && t < 50) begin
            @(negedge clk);
            if (tl_bus.d_valid) got++;
            @(posedge clk); #1;
            t++;
        end
        check("beats_before_reset", 64'(got), 64'd4);
        reset = 1'b0;
        #1;
        check("d_valid_on_reset", {63'd0, tl_bus.d_valid}, 64'd0);
        @(negedge clk);
        check("a_ready_in_reset", {63'd0, tl_bus.a_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_a_ready("a_ready_after_midburst_reset");
        tl_bus.d_ready = 1'b0;
        do_get(BASE + 32'h80, 3'd6, 2'd0, 0, 1'b0);

        // Random traffic checked against the word-array model.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            put  = 1'($urandom_range(0, 1));
            sz   = 3'($urandom_range(0, 6));
            mode = int'($urandom_range(0, 1));
            if (kind < 8) begin
                a = BASE + 32'($urandom_range(0, WIN - 1));
            end else begin
                a = BASE + 32'(WIN) + 32'($urandom_range(0, 255) * 8);
                if (put) sz = 3'($urandom_range(0, 3));
            end
            if (put) begin
                for (int k = 0; k < 8; k++) begin
                    put_data[k] = {$urandom, $urandom};
                    put_mask[k] = 8'($urandom);
                end
                do_put(a, sz, 2'($urandom));
            end else begin
                do_get(a, sz, 2'($urandom), mode, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
